// File: rtl/pkg_cmd.sv
// Shared command types and sizing constants for the command queue and its
// neighbours (top, issuer).
package pkg_cmd;

    localparam int unsigned MEM_SIZE        = 256;
    localparam int unsigned MEM_ADDR_W      = $clog2(MEM_SIZE);
    localparam int unsigned CMD_QUEUE_DEPTH = 16;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_MUL   = 3'd5,
        OP_JMP   = 3'd6,
        OP_HALT  = 3'd7
    } cmd_op_t;

    typedef struct packed {
        cmd_op_t                 op;
        logic [3:0]              tag;
        logic [MEM_ADDR_W-1:0]   addr;
    } cmd_t;

endpackage

// File: rtl/cmd_queue_ram.sv
// Command storage: DEPTH x cmd_t register file, two write ports and one
// combinational read port. Contents are not reset.
module cmd_queue_ram
    import pkg_cmd::*;
#(
    parameter int unsigned DEPTH = CMD_QUEUE_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  cmd_t          wdata0,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  cmd_t          wdata1,
    input  logic [AW-1:0] raddr,
    output cmd_t          rdata
);

    cmd_t mem [DEPTH];

    // The queue never aims both ports at one slot; port 1 wins if it ever did.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cmd_queue.sv
// Circular command FIFO feeding the issuer: host pushes, issuer re-queues,
// registered pop with one-cycle ack, one slot reserved for re-queues.
module cmd_queue
    import pkg_cmd::*;
#(
    parameter int unsigned DEPTH = CMD_QUEUE_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             host_wr,
    input  cmd_t             host_cmd,
    output logic             host_full,
    input  logic             issuer_rd_queue,
    input  logic             issuer_wr_queue,
    input  cmd_t             issuer_cmd,
    output cmd_t             queue_cmd,
    output logic             queue_ack,
    output logic             queue_empty,
    output logic [CNT_W-1:0] queue_count,
    output logic             ovf_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    host_addr;
    logic [AW-1:0]    wptr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             acc_pop;
    logic             acc_rq;
    logic             acc_host;
    cmd_t             head;

    always_comb begin
        acc_pop  = issuer_rd_queue && (count != '0);
        // A pop frees its slot in the same cycle, so re-queue is legal even when full.
        acc_rq   = issuer_wr_queue &&
                   ((count - CNT_W'(acc_pop)) < CNT_W'(DEPTH));
        acc_host = host_wr && !host_full;

        host_addr  = wptr + AW'(acc_rq);
        wptr_next  = wptr + AW'(acc_rq) + AW'(acc_host);
        count_next = count + CNT_W'(acc_rq) + CNT_W'(acc_host) - CNT_W'(acc_pop);
    end

    cmd_queue_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk    (i_clk),
        .we0    (acc_rq),
        .waddr0 (wptr),
        .wdata0 (issuer_cmd),
        .we1    (acc_host),
        .waddr1 (host_addr),
        .wdata1 (host_cmd),
        .raddr  (rptr),
        .rdata  (head)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rptr        <= '0;
            wptr        <= '0;
            count       <= '0;
            queue_cmd   <= '0;
            queue_ack   <= 1'b0;
            ovf_err     <= 1'b0;
            host_full   <= 1'b0;
            queue_empty <= 1'b1;
        end else begin
            wptr        <= wptr_next;
            count       <= count_next;
            queue_ack   <= acc_pop;
            host_full   <= (count_next >= CNT_W'(DEPTH - 1));
            queue_empty <= (count_next == '0);
            if (acc_pop) begin
                queue_cmd <= head;
                rptr      <= rptr + 1'b1;
            end
            if (issuer_wr_queue && !acc_rq) ovf_err <= 1'b1;
        end
    end

    assign queue_count = count;

endmodule

// File: tb/tb_cmd_queue.sv
// Scoreboard bench for cmd_queue: accepted writes are queued as expected pops
// and compared when the ack arrives.
module tb_cmd_queue;
    import pkg_cmd::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             i_clk;
    logic             i_rstn;
    logic             host_wr;
    cmd_t             host_cmd;
    logic             host_full;
    logic             issuer_rd_queue;
    logic             issuer_wr_queue;
    cmd_t             issuer_cmd;
    cmd_t             queue_cmd;
    logic             queue_ack;
    logic             queue_empty;
    logic [CNT_W-1:0] queue_count;
    logic             ovf_err;

    cmd_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .host_wr         (host_wr),
        .host_cmd        (host_cmd),
        .host_full       (host_full),
        .issuer_rd_queue (issuer_rd_queue),
        .issuer_wr_queue (issuer_wr_queue),
        .issuer_cmd      (issuer_cmd),
        .queue_cmd       (queue_cmd),
        .queue_ack       (queue_ack),
        .queue_empty     (queue_empty),
        .queue_count     (queue_count),
        .ovf_err         (ovf_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int   total = 0;
    int   bad   = 0;
    cmd_t sb[$];
    int   mcount = 0;
    bit   movf   = 1'b0;
    cmd_t last_cmd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input int unsigned v);
        cmd_t c;
        c.op   = cmd_op_t'(v[2:0]);
        c.tag  = v[6:3];
        c.addr = v[14:7];
        return c;
    endfunction

    task automatic check_status(input string tag);
        chk({tag, ".count"}, 32'(queue_count), 32'(mcount));
        chk({tag, ".empty"}, 32'(queue_empty), 32'(mcount == 0));
        chk({tag, ".full"},  32'(host_full),   32'(mcount >= int'(DEPTH) - 1));
        chk({tag, ".ovf"},   32'(ovf_err),     32'(movf));
    endtask

    // Called at posedge+1: drives one cycle of stimulus, then checks after the edge.
    task automatic step(input string tag, input bit rd, input bit rq, input cmd_t rqc,
                        input bit hw, input cmd_t hc);
        int   ap, ar, ah;
        cmd_t exp;
        issuer_rd_queue = rd;
        issuer_wr_queue = rq;
        issuer_cmd      = rqc;
        host_wr         = hw;
        host_cmd        = hc;
        ap = (rd && mcount > 0) ? 1 : 0;
        ar = (rq && (mcount - ap) < int'(DEPTH)) ? 1 : 0;
        ah = (hw && mcount < int'(DEPTH) - 1) ? 1 : 0;
        if (ap == 1) begin
            exp      = sb.pop_front();
            last_cmd = exp;
        end
        if (ar == 1) sb.push_back(rqc);
        if (ah == 1) sb.push_back(hc);
        if (rq && ar == 0) movf = 1'b1;
        mcount = mcount + ar + ah - ap;
        @(posedge i_clk);
        #1;
        issuer_rd_queue = 1'b0;
        issuer_wr_queue = 1'b0;
        host_wr         = 1'b0;
        chk({tag, ".ack"}, 32'(queue_ack), 32'(ap));
        chk({tag, ".cmd"}, 32'(queue_cmd), 32'(last_cmd));
        check_status(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset(input int ncyc);
        i_rstn          = 1'b0;
        host_wr         = 1'b0;
        issuer_rd_queue = 1'b0;
        issuer_wr_queue = 1'b0;
        host_cmd        = '0;
        issuer_cmd      = '0;
        repeat (ncyc) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        sb.delete();
        mcount   = 0;
        movf     = 1'b0;
        last_cmd = '0;
        chk("rst.ack", 32'(queue_ack), 32'd0);
        chk("rst.cmd", 32'(queue_cmd), 32'd0);
        check_status("rst");
    endtask

    initial begin
        cmd_t a, b, c, d, x, y;
        a = mk(32'h1235); b = mk(32'h2a4b); c = mk(32'h7f01); d = mk(32'h3c6d);
        x = mk(32'h5557); y = mk(32'h6ee2);

        // reset then idle
        do_reset(3);
        idle("idle");

        // basic FIFO order
        step("push", 1'b0, 1'b0, '0, 1'b1, a);
        step("push", 1'b0, 1'b0, '0, 1'b1, b);
        step("push", 1'b0, 1'b0, '0, 1'b1, c);
        repeat (3) step("pop", 1'b1, 1'b0, '0, 1'b0, '0);

        // pop on empty: no ack, queue_cmd holds C
        repeat (2) step("pop_empty", 1'b1, 1'b0, '0, 1'b0, '0);

        // reserved slot and overflow
        for (int i = 0; i < 15; i++) step("fill", 1'b0, 1'b0, '0, 1'b1, mk(32'(i * 977 + 13)));
        step("host_drop", 1'b0, 1'b0, '0, 1'b1, y);
        step("rq_last", 1'b0, 1'b1, x, 1'b0, '0);
        step("rq_ovf", 1'b0, 1'b1, y, 1'b0, '0);
        step("pop_rq_full", 1'b1, 1'b1, d, 1'b0, '0);
        for (int i = 0; i < 17; i++) step("drain", 1'b1, 1'b0, '0, 1'b0, '0);
        do_reset(1);

        // stall / re-queue round trip
        step("push", 1'b0, 1'b0, '0, 1'b1, a);
        step("push", 1'b0, 1'b0, '0, 1'b1, b);
        step("pop_rq_push", 1'b1, 1'b1, a, 1'b1, d);
        repeat (3) step("rt_pop", 1'b1, 1'b0, '0, 1'b0, '0);

        // push/pop pairs across pointer wrap
        step("wrap_pre", 1'b0, 1'b0, '0, 1'b1, mk($urandom));
        for (int i = 0; i < 40; i++) step("wrap", 1'b1, 1'b0, '0, 1'b1, mk($urandom));
        step("wrap_last", 1'b1, 1'b0, '0, 1'b0, '0);

        // random mixed traffic
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
                 mk($urandom), 1'($urandom_range(0, 1)), mk($urandom));
        for (int i = 0; i < 18; i++) step("rand_drain", 1'b1, 1'b0, '0, 1'b0, '0);
        do_reset(1);

        // mid-op reset between pop request and its ack
        step("mr_push", 1'b0, 1'b0, '0, 1'b1, a);
        step("mr_push", 1'b0, 1'b0, '0, 1'b1, b);
        issuer_rd_queue = 1'b1;
        #2;
        i_rstn = 1'b0;
        #1;
        chk("mr.count_now", 32'(queue_count), 32'd0);
        chk("mr.ack_now", 32'(queue_ack), 32'd0);
        @(posedge i_clk);
        #1;
        chk("mr.ack_edge", 32'(queue_ack), 32'd0);
        issuer_rd_queue = 1'b0;
        i_rstn = 1'b1;
        sb.delete();
        mcount   = 0;
        movf     = 1'b0;
        last_cmd = '0;
        idle("mr_after");
        step("mr_pop_empty", 1'b1, 1'b0, '0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_queue.md
Name: cmd_queue

Overview:
- Circular command FIFO that sits directly upstream of the issuer inside top, and drives its queue_cmd/queue_ack inputs.
- Two write sources: the host/loader, which pushes new commands, and the issuer, which re-queues a stalled command to the tail over issuer_wr_queue/issuer_cmd.
- The issuer pops over issuer_rd_queue. The popped command is returned registered, with a one-cycle ack.
- One slot is always reserved for issuer re-queues, so a dependency stall never deadlocks or drops a command.

Parameters:
- DEPTH, 16: number of cmd_t entries. Must be a power of two, >= 4.
- CNT_W, $clog2(DEPTH+1): width of the occupancy counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rstn  in  1  asynchronous, active-low reset
- host_wr  in  1  host push request; accepted only when host_full=0
- host_cmd  in  cmd_t  command pushed by the host
- host_full  out  1  high when count >= DEPTH-1 (reserved-slot rule)
- issuer_rd_queue  in  1  pop request from the issuer
- issuer_wr_queue  in  1  re-queue request from the issuer
- issuer_cmd  in  cmd_t  command being re-queued
- queue_cmd  out  cmd_t  registered popped command; held until the next successful pop
- queue_ack  out  1  one-cycle pulse: queue_cmd holds a newly popped command
- queue_empty  out  1  count == 0
- queue_count  out  CNT_W  current occupancy
- ovf_err  out  1  sticky flag: a re-queue was dropped because the queue was full

Behaviour:
- Reset (asynchronous, i_rstn=0):
  - read pointer, write pointer and count = 0
  - queue_cmd = '0, queue_ack = 0, ovf_err = 0
  - host_full = 0, queue_empty = 1
  - storage contents are don't-care
  - a reset in the middle of traffic discards all entries; any pending ack is cancelled
- Pop:
  - If issuer_rd_queue=1 at edge N and count>0 (count before the edge), the head is written into queue_cmd and the read pointer advances.
  - queue_ack=1 during cycle N+1 only. Pop latency is exactly 1 cycle.
  - If issuer_rd_queue=1 with count==0, the request is ignored: queue_ack stays 0 and the issuer must re-assert.
  - A push in the same cycle is never forwarded to the pop (no bypass).
- Writes per cycle: at most two, the re-queue first, then the host.
  - The re-queue is accepted when count - pop < DEPTH, and is written at wptr.
  - The host push is accepted when host_full=0. It is written at wptr+1 if a re-queue was also accepted, otherwise at wptr.
  - A re-queue that is refused sets ovf_err; the command is lost.
  - host_wr while host_full=1 is dropped silently. The host is responsible for checking host_full.
- Update rules:
  - count_next = count + acc_rq + acc_host - acc_pop
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - host_full, queue_empty and queue_count are registered values derived from count.
- Reserved slot:
  - Host pushes are refused at count=DEPTH-1, so at least one slot is kept for a re-queue.
  - A pop and a re-queue in the same cycle are both accepted even at count=DEPTH.
- Simultaneous pop, re-queue and host push: all three are legal in one cycle, with net count change +1.
- Ordering: strict FIFO. A re-queued command goes behind every entry already in the queue.

Decomposition:
- Shared package (pkg_cmd):
  - the cmd_t typedef (the same type that top and the issuer use)
  - MEM_SIZE
  - the default CMD_QUEUE_DEPTH
- One natural sub-module, cmd_queue_ram: a DEPTH x cmd_t register file with 2 write ports and 1 combinational read port.
- Pointer, count and handshake logic stay in cmd_queue.

Test Plan:
1. Reset then idle:
   - hold i_rstn=0 for 3 cycles, then release
   - required: queue_empty=1, queue_count=0, queue_ack=0, host_full=0, ovf_err=0
2. Basic FIFO order:
   - push host cmds A, B, C on consecutive cycles, then issuer_rd_queue for 3 cycles
   - required: queue_ack high on 3 consecutive cycles, each 1 cycle after its request, with queue_cmd = A, B, C; then queue_empty=1
3. Pop on empty:
   - issuer_rd_queue=1 with count=0 for 2 cycles
   - required: queue_ack stays 0; queue_cmd keeps its previous value
4. Reserved slot:
   - DEPTH=16; push 15 host cmds
   - required: host_full=1 and a 16th host_wr is dropped (count stays 15)
   - then issuer_wr_queue X: count=16, ovf_err=0
   - a further re-queue without a pop sets ovf_err=1
5. Stall/re-queue round trip:
   - queue holds A, B; pop A; issuer re-queues A in the same cycle as host pushes D
   - required: count 2→3; pop order is then B, A, D
6. Wrap and mid-op reset:
   - run 40 push/pop pairs with DEPTH=16
   - required: data stays in order across pointer wrap
   - assert i_rstn=0 for 1 cycle between a pop request and its ack: queue_ack never pulses and count=0 immediately
